status_bank: RTL

- Holds the committed 12-bit program status (CPSR) and the five banked SPSRs of the pipelined LEG core.
- Consumes the decode-stage exception-return request (restoreCPSR_D) and carries it down the pipeline to writeback.
- Applies exception entry, exception return, MSR writes and ALU flag updates at W.
- Feeds the current-mode SPSR back to decode as PreviousStatusD.

---
 rtl/status_bank_pkg.sv | 67 ++++++
 rtl/status_bank_if.sv | 34 +++
 rtl/status_bank_spsr_bank.sv | 43 ++++
 rtl/status_bank.sv | 109 ++++++++++
 4 files changed

// File: rtl/status_bank_pkg.sv
// Shared definitions for the LEG status unit: mode encodings, status field
// positions, exception types and mode helpers.
package leg_status_pkg;

  localparam int unsigned STATUS_W = 12;
  localparam int unsigned NUM_SPSR = 5;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int unsigned BIT_N    = 11;
  localparam int unsigned BIT_Z    = 10;
  localparam int unsigned BIT_C    = 9;
  localparam int unsigned BIT_V    = 8;
  localparam int unsigned BIT_I    = 7;
  localparam int unsigned BIT_F    = 6;
  localparam int unsigned BIT_T    = 5;
  localparam int unsigned MODE_HI  = 4;
  localparam int unsigned MODE_LO  = 0;

  typedef enum logic [2:0] {
    EXC_RESET = 3'd0,
    EXC_UNDEF = 3'd1,
    EXC_SWI   = 3'd2,
    EXC_PABT  = 3'd3,
    EXC_DABT  = 3'd4,
    EXC_IRQ   = 3'd5,
    EXC_FIQ   = 3'd6,
    EXC_NONE  = 3'd7
  } exc_type_e;

  function automatic logic is_valid_mode(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] exc_to_mode(input exc_type_e e);
    case (e)
      EXC_UNDEF:          return MODE_UND;
      EXC_PABT, EXC_DABT: return MODE_ABT;
      EXC_IRQ:            return MODE_IRQ;
      EXC_FIQ:            return MODE_FIQ;
      default:            return MODE_SVC;
    endcase
  endfunction

  // Bank slot for a mode; 7 means the mode has no SPSR.
  function automatic logic [2:0] spsr_index(input logic [4:0] m);
    case (m)
      MODE_FIQ: return 3'd0;
      MODE_IRQ: return 3'd1;
      MODE_SVC: return 3'd2;
      MODE_ABT: return 3'd3;
      MODE_UND: return 3'd4;
      default:  return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/status_bank_if.sv
// Decode/pipeline/writeback signal bundle between the core and the status unit.
interface status_bank_if;
  import leg_status_pkg::*;

  logic                restoreCPSR_D;
  logic                StallE, StallM, StallW;
  logic                FlushE, FlushM, FlushW;
  logic                ExcTakenW;
  logic [2:0]          ExcTypeW;
  logic                MSRWriteW;
  logic                MSRSpsrW;
  logic [1:0]          MSRMaskW;
  logic [STATUS_W-1:0] MSRDataW;
  logic                FlagWriteW;
  logic [3:0]          FlagsW;
  logic [STATUS_W-1:0] CPSR;
  logic [STATUS_W-1:0] PreviousStatusD;
  logic                StatusBusyD;
  logic                RestoreDoneW;

  modport master (
    output restoreCPSR_D, StallE, StallM, StallW, FlushE, FlushM, FlushW,
           ExcTakenW, ExcTypeW, MSRWriteW, MSRSpsrW, MSRMaskW, MSRDataW,
           FlagWriteW, FlagsW,
    input  CPSR, PreviousStatusD, StatusBusyD, RestoreDoneW
  );

  modport slave (
    input  restoreCPSR_D, StallE, StallM, StallW, FlushE, FlushM, FlushW,
           ExcTakenW, ExcTypeW, MSRWriteW, MSRSpsrW, MSRMaskW, MSRDataW,
           FlagWriteW, FlagsW,
    output CPSR, PreviousStatusD, StatusBusyD, RestoreDoneW
  );
endinterface

// File: rtl/status_bank_spsr_bank.sv
// Five banked SPSRs with a field-masked write port and a mode-indexed read
// port; USR/SYS (and any unbanked mode) read as zero and ignore writes.
module spsr_bank
  import leg_status_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [4:0]          wr_mode,
  input  logic [STATUS_W-1:0] wr_data,
  input  logic [1:0]          wr_mask,
  input  logic [4:0]          rd_mode,
  output logic [STATUS_W-1:0] rd_data
);

  logic [STATUS_W-1:0] spsr_q [NUM_SPSR];
  logic [2:0]          wr_idx;
  logic [2:0]          rd_idx;

  assign wr_idx = spsr_index(wr_mode);
  assign rd_idx = spsr_index(rd_mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SPSR; i++) begin
        if (wr_en && wr_idx == 3'(i)) begin
          if (wr_mask[1]) spsr_q[i][BIT_N:BIT_V] <= wr_data[BIT_N:BIT_V];
          if (wr_mask[0]) spsr_q[i][BIT_I:MODE_LO] <= wr_data[BIT_I:MODE_LO];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_SPSR; i++) begin
      if (rd_idx == 3'(i)) rd_data = spsr_q[i];
    end
  end

endmodule

// File: rtl/status_bank.sv
// Committed CPSR, banked SPSRs and the exception-return pipeline (E/M/W)
// of the LEG core; all status writes commit at writeback.
module status_bank
  import leg_status_pkg::*;
#(
  parameter logic [STATUS_W-1:0] RESET_STATUS = 12'h0D3
) (
  input logic          clk,
  input logic          reset,
  status_bank_if.slave bus
);

  logic [STATUS_W-1:0] cpsr_q, cpsr_d;
  logic                restore_e, restore_m, restore_w;
  logic                done_q, restore_commit;
  logic [4:0]          cur_mode, new_mode;
  logic                cur_banked;
  exc_type_e           exc;

  logic                sp_we;
  logic [4:0]          sp_mode;
  logic [STATUS_W-1:0] sp_data, sp_rd;
  logic [1:0]          sp_mask;

  assign exc        = exc_type_e'(bus.ExcTypeW);
  assign cur_mode   = cpsr_q[MODE_HI:MODE_LO];
  assign cur_banked = (spsr_index(cur_mode) != 3'd7);

  spsr_bank u_spsr_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (sp_we),
    .wr_mode (sp_mode),
    .wr_data (sp_data),
    .wr_mask (sp_mask),
    .rd_mode (cur_mode),
    .rd_data (sp_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      restore_e <= 1'b0;
      restore_m <= 1'b0;
      restore_w <= 1'b0;
      done_q    <= 1'b0;
      cpsr_q    <= RESET_STATUS;
    end else begin
      if (bus.FlushE)      restore_e <= 1'b0;
      else if (!bus.StallE) restore_e <= bus.restoreCPSR_D;
      if (bus.FlushM)      restore_m <= 1'b0;
      else if (!bus.StallM) restore_m <= restore_e;
      if (bus.FlushW)      restore_w <= 1'b0;
      else if (!bus.StallW) restore_w <= restore_m;
      done_q <= restore_commit;
      cpsr_q <= cpsr_d;
    end
  end

  // Exception entry, restore and MSR are mutually exclusive by priority;
  // ALU flags only land when none of them claims the writeback slot.
  always_comb begin
    cpsr_d         = cpsr_q;
    restore_commit = 1'b0;
    new_mode       = exc_to_mode(exc);
    sp_we          = 1'b0;
    sp_mode        = cur_mode;
    sp_data        = cpsr_q;
    sp_mask        = 2'b11;
    if (!bus.StallW) begin
      if (bus.ExcTakenW) begin
        if (exc != EXC_NONE) begin
          sp_we   = 1'b1;
          sp_mode = new_mode;
          cpsr_d[BIT_I] = 1'b1;
          if (exc == EXC_RESET || exc == EXC_FIQ) cpsr_d[BIT_F] = 1'b1;
          cpsr_d[BIT_T] = 1'b0;
          cpsr_d[MODE_HI:MODE_LO] = new_mode;
        end
      end else if (restore_w) begin
        restore_commit = 1'b1;
        if (cur_banked) cpsr_d = sp_rd;
      end else if (bus.MSRWriteW) begin
        if (bus.MSRSpsrW) begin
          sp_we   = cur_banked;
          sp_data = bus.MSRDataW;
          sp_mask = bus.MSRMaskW;
        end else begin
          if (bus.MSRMaskW[1]) cpsr_d[BIT_N:BIT_V] = bus.MSRDataW[BIT_N:BIT_V];
          if (bus.MSRMaskW[0]) begin
            cpsr_d[BIT_I:BIT_T] = bus.MSRDataW[BIT_I:BIT_T];
            if (is_valid_mode(bus.MSRDataW[MODE_HI:MODE_LO]))
              cpsr_d[MODE_HI:MODE_LO] = bus.MSRDataW[MODE_HI:MODE_LO];
          end
        end
      end else if (bus.FlagWriteW) begin
        cpsr_d[BIT_N] = bus.FlagsW[3];
        cpsr_d[BIT_Z] = bus.FlagsW[2];
        cpsr_d[BIT_C] = bus.FlagsW[1];
        cpsr_d[BIT_V] = bus.FlagsW[0];
      end
    end
  end

  assign bus.CPSR            = cpsr_q;
  assign bus.PreviousStatusD = sp_rd;
  assign bus.StatusBusyD     = restore_e | restore_m | restore_w;
  assign bus.RestoreDoneW    = done_q;

endmodule
